// File: rtl/w5300_pkg.sv
// Shared encodings and constants for the W5300 host-bus responder.
package w5300_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_e;

  localparam logic [9:0]  IDR_ADDR    = 10'h3FE;
  localparam logic [15:0] IDR_DEFAULT = 16'h5300;
  localparam logic        RW_READ     = 1'b1;
  localparam logic        RW_WRITE    = 1'b0;

  function automatic logic idx_in_range(input logic [8:0] idx, input int depth);
    return {23'd0, idx} < $unsigned(depth);
  endfunction

endpackage

// File: rtl/w5300_parallel_if_responder_if.sv
// Host-bus control/address pins; the tristate data bus stays a plain inout on the responder.
interface w5300_parallel_if_responder_if;
  logic [9:0] addr;
  logic       cs_n;
  logic       rd_n;
  logic       we_n;
  logic       rw_n;

  modport master (output addr, cs_n, rd_n, we_n, rw_n);
  modport slave  (input  addr, cs_n, rd_n, we_n, rw_n);
endinterface

// File: rtl/w5300_resp_regfile.sv
// DEPTH x 16 register file: one write port, a combinational pin-read port, a registered peek port.
module w5300_resp_regfile
  import w5300_pkg::*;
#(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [8:0]    widx,
  input  logic [15:0]   wdata,
  input  logic [8:0]    ridx,
  output logic [15:0]   rdata,
  input  logic [AW-1:0] pidx,
  output logic [15:0]   pdata
);

  logic [15:0] regs_q [DEPTH];
  logic [15:0] regs_d [DEPTH];
  logic [15:0] pdata_q, pdata_d;

  always_comb begin
    regs_d = regs_q;
    if (we && idx_in_range(widx, DEPTH)) regs_d[widx[AW-1:0]] = wdata;
  end

  always_comb begin
    rdata = '0;
    if (idx_in_range(ridx, DEPTH)) rdata = regs_q[ridx[AW-1:0]];
  end

  // Peek reads the pre-commit contents, so a same-cycle write shows up one cycle later.
  always_comb begin
    pdata_d = '0;
    if ({{(32-AW){1'b0}}, pidx} < $unsigned(DEPTH)) pdata_d = regs_q[pidx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pdata_q <= '0;
    end else begin
      regs_q  <= regs_d;
      pdata_q <= pdata_d;
    end
  end

  assign pdata = pdata_q;

endmodule

// File: rtl/w5300_parallel_if_responder.sv
// Chip-side responder for the W5300 16-bit parallel host bus: register file, ID register,
// write commit on we_n release, sticky protocol-violation flag.
module w5300_parallel_if_responder
  import w5300_pkg::*;
#(
  parameter int          DEPTH   = 64,
  parameter int          RD_LAT  = 0,
  parameter logic [15:0] IDR_VAL = IDR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  w5300_parallel_if_responder_if.slave bus,
  inout  wire  [15:0]              data,
  input  logic [$clog2(DEPTH)-1:0] l_addr,
  output logic [15:0]              l_rdata,
  output logic                     wr_strobe,
  output logic [9:0]               wr_addr,
  output logic [15:0]              wr_data,
  output logic [15:0]              rd_cnt,
  output logic [15:0]              wr_cnt,
  output logic                     proto_err,
  input  logic                     err_clr
);

  logic        cs_q, rd_q, we_q, rw_q;
  logic [9:0]  addr_q;
  logic [15:0] data_q;

  state_e      state_q, state_d;
  logic [9:0]  pend_addr_q, pend_addr_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [9:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        err_q, err_d;
  logic [7:0]  lat_cnt_q, lat_cnt_d;

  logic        err_set, rf_we, drive_en;
  logic [9:0]  rd_addr;
  logic [15:0] rf_rdata, rd_word;

  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    err_set     = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        lat_cnt_d = '0;
        if (!cs_q) begin
          if (!rd_q && !we_q) begin
            err_set = 1'b1;
          end else if (!rd_q) begin
            state_d  = S_RD;
            rd_cnt_d = rd_cnt_q + 16'd1;
          end else if (!we_q) begin
            state_d     = S_WR;
            pend_addr_d = addr_q;
            pend_data_d = data_q;
          end
        end
      end
      S_RD: begin
        if (!we_q || rw_q == RW_WRITE) err_set = 1'b1;
        if (cs_q || rd_q) state_d = S_IDLE;
        else if (lat_cnt_q != 8'hFF) lat_cnt_d = lat_cnt_q + 8'd1;
      end
      S_WR: begin
        if (!rd_q || rw_q == RW_READ) err_set = 1'b1;
        if (we_q || cs_q) begin
          // Last sample taken while we_n was low is what commits.
          state_d     = S_IDLE;
          rf_we       = (pend_addr_q != IDR_ADDR);
          wr_strobe_d = 1'b1;
          wr_addr_d   = pend_addr_q;
          wr_data_d   = pend_data_q;
          wr_cnt_d    = wr_cnt_q + 16'd1;
        end else begin
          pend_addr_d = addr_q;
          pend_data_d = data_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      we_q        <= 1'b1;
      rw_q        <= RW_READ;
      addr_q      <= '0;
      data_q      <= '0;
      state_q     <= S_IDLE;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
      err_q       <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      cs_q        <= bus.cs_n;
      rd_q        <= bus.rd_n;
      we_q        <= bus.we_n;
      rw_q        <= bus.rw_n;
      addr_q      <= bus.addr;
      data_q      <= data;
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      err_q       <= err_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  // Zero latency drives straight off the pins; otherwise the FSM's registered view owns the bus.
  always_comb begin
    rd_addr  = (RD_LAT == 0) ? bus.addr : addr_q;
    drive_en = 1'b0;
    if (!rst) begin
      if (RD_LAT == 0) drive_en = !bus.cs_n && !bus.rd_n && bus.we_n;
      else             drive_en = (state_q == S_RD) && (lat_cnt_q >= 8'(RD_LAT));
    end
    rd_word = (rd_addr == IDR_ADDR) ? IDR_VAL : rf_rdata;
  end

  assign data = drive_en ? rd_word : 16'hzzzz;

  w5300_resp_regfile #(.DEPTH(DEPTH)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (rf_we),
    .widx  (pend_addr_q[9:1]),
    .wdata (pend_data_q),
    .ridx  (rd_addr[9:1]),
    .rdata (rf_rdata),
    .pidx  (l_addr),
    .pdata (l_rdata)
  );

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  assign proto_err = err_q;

endmodule

// File: tb/tb_w5300_parallel_if_responder.sv
// Bench for the W5300 responder: vector table, random traffic against an array model, corner sequences.
module tb_w5300_parallel_if_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  w5300_parallel_if_responder_if bus ();

  wire  [15:0] data;
  logic [15:0] tb_drv = 16'h0000;
  logic        tb_oe  = 1'b0;
  assign data = tb_oe ? tb_drv : 16'hzzzz;
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (data[i]);
  end

  logic [5:0]  l_addr  = '0;
  logic        err_clr = 1'b0;
  logic [15:0] l_rdata, wr_data, rd_cnt, wr_cnt;
  logic [9:0]  wr_addr;
  logic        wr_strobe, proto_err;

  w5300_parallel_if_responder dut (
    .clk(clk), .rst(rst), .bus(bus), .data(data),
    .l_addr(l_addr), .l_rdata(l_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .proto_err(proto_err), .err_clr(err_clr)
  );

  int n_chk = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  logic [15:0] mem [64];
  logic [15:0] m_rd_cnt, m_wr_cnt;
  logic        m_err;

  always @(negedge clk) if (wr_strobe) strobe_cnt++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] exp_read(input logic [9:0] a);
    if (a == 10'h3FE) return 16'h5300;
    if (a[9:1] < 9'd64) return mem[a[6:1]];
    return 16'h0000;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    m_rd_cnt = 0;
    m_wr_cnt = 0;
    m_err    = 1'b0;
  endtask

  task automatic pins_idle();
    bus.cs_n = 1'b1; bus.rd_n = 1'b1; bus.we_n = 1'b1; bus.rw_n = 1'b1;
    tb_oe = 1'b0;
  endtask

  task automatic bus_write(input logic [9:0] a, input logic [15:0] d, input int nlow);
    int s0;
    s0 = strobe_cnt;
    step();
    bus.addr = a; tb_drv = d; tb_oe = 1'b1;
    bus.cs_n = 1'b0; bus.rw_n = 1'b0; bus.we_n = 1'b0;
    repeat (nlow) step();
    bus.we_n = 1'b1;
    step();
    pins_idle();
    step();
    step();
    if (a != 10'h3FE && a[9:1] < 9'd64) mem[a[6:1]] = d;
    m_wr_cnt++;
    @(negedge clk);
    chk("wr_pulses", strobe_cnt - s0, 1);
    chk("wr_addr", wr_addr, a);
    chk("wr_data", wr_data, d);
    chk("wr_cnt", wr_cnt, m_wr_cnt);
    chk("wr_proto_err", proto_err, m_err);
  endtask

  task automatic bus_read(input logic [9:0] a);
    logic [15:0] e;
    e = exp_read(a);
    step();
    bus.addr = a; bus.rw_n = 1'b1; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    @(negedge clk);
    chk("rd_data_first", data, e);
    step();
    step();
    @(negedge clk);
    chk("rd_data_held", data, e);
    bus.rd_n = 1'b1;
    #1;
    chk("rd_release", data, 16'hFFFF);
    step();
    bus.cs_n = 1'b1;
    step();
    step();
    m_rd_cnt++;
    chk("rd_cnt", rd_cnt, m_rd_cnt);
  endtask

  task automatic peek(input logic [5:0] i);
    step();
    l_addr = i;
    step();
    @(negedge clk);
    chk("peek", l_rdata, mem[i]);
  endtask

  function automatic logic [9:0] rand_addr();
    logic [8:0] idx;
    int r;
    r = $urandom_range(0, 7);
    if (r < 6) begin
      idx = 9'($urandom_range(0, 63));
      return {idx, 1'($urandom_range(0, 1))};
    end
    if (r == 6) return 10'h3FE;
    idx = 9'($urandom_range(64, 510));
    return {idx, 1'b0};
  endfunction

  typedef struct {
    logic       is_wr;
    logic [9:0] addr;
    logic [15:0] val;   // write data, or expected read data
  } vec_t;

  vec_t vecs [12];
  int s0;

  initial begin
    vecs[0]  = '{1'b1, 10'h004, 16'hA5A5};
    vecs[1]  = '{1'b0, 10'h004, 16'hA5A5};
    vecs[2]  = '{1'b0, 10'h3FE, 16'h5300};
    vecs[3]  = '{1'b1, 10'h3FE, 16'h1234};
    vecs[4]  = '{1'b0, 10'h3FE, 16'h5300};
    vecs[5]  = '{1'b1, 10'h200, 16'hCAFE};
    vecs[6]  = '{1'b0, 10'h200, 16'h0000};
    vecs[7]  = '{1'b1, 10'h07E, 16'h1357};
    vecs[8]  = '{1'b0, 10'h07F, 16'h1357};
    vecs[9]  = '{1'b1, 10'h080, 16'h2468};
    vecs[10] = '{1'b0, 10'h080, 16'h0000};
    vecs[11] = '{1'b0, 10'h005, 16'hA5A5};

    bus.addr = '0;
    pins_idle();
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_data_z", data, 16'hFFFF);
    chk("rst_l_rdata", l_rdata, 0);
    chk("rst_wr_strobe", wr_strobe, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_proto_err", proto_err, 0);

    for (int k = 0; k < 12; k++) begin
      if (vecs[k].is_wr) begin
        bus_write(vecs[k].addr, vecs[k].val, 3);
      end else begin
        chk("vec_model", exp_read(vecs[k].addr), vecs[k].val);
        bus_read(vecs[k].addr);
      end
    end
    peek(6'd2);
    peek(6'd63);

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 2))
        0: bus_write(rand_addr(), 16'($urandom_range(0, 16'hFFFE)), $urandom_range(1, 3));
        1: bus_read(rand_addr());
        default: peek(6'($urandom_range(0, 63)));
      endcase
    end

    // Read and write strobes together: error, no commit, sticky until cleared.
    s0 = strobe_cnt;
    step();
    bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.we_n = 1'b0; bus.rw_n = 1'b1;
    repeat (3) step();
    pins_idle();
    step();
    step();
    m_err = 1'b1;
    @(negedge clk);
    chk("err_set", proto_err, m_err);
    chk("err_no_commit", strobe_cnt - s0, 0);
    chk("err_wr_cnt", wr_cnt, m_wr_cnt);
    step();
    step();
    @(negedge clk);
    chk("err_sticky", proto_err, 1);
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared", proto_err, 0);

    // Clear and a fresh error in the same cycle: the error wins.
    step();
    bus.cs_n = 1'b0; bus.rd_n = 1'b0; bus.we_n = 1'b0;
    step();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    pins_idle();
    @(negedge clk);
    chk("err_set_wins", proto_err, 1);
    step();
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_cleared2", proto_err, 0);

    // Reset in the middle of a write drops the pending data.
    s0 = strobe_cnt;
    step();
    bus.addr = 10'h006; tb_drv = 16'hBEEF; tb_oe = 1'b1;
    bus.cs_n = 1'b0; bus.rw_n = 1'b0; bus.we_n = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    pins_idle();
    step();
    step();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rstwr_no_strobe", strobe_cnt - s0, 0);
    chk("rstwr_wr_cnt", wr_cnt, 0);
    chk("rstwr_rd_cnt", rd_cnt, 0);
    chk("rstwr_data_z", data, 16'hFFFF);
    peek(6'd3);
    peek(6'd2);

    // Reset during a read releases the bus in that very cycle.
    step();
    bus.addr = 10'h3FE; bus.rw_n = 1'b1; bus.cs_n = 1'b0; bus.rd_n = 1'b0;
    @(negedge clk);
    chk("rstrd_driven", data, 16'h5300);
    rst = 1'b1;
    #1;
    chk("rstrd_release", data, 16'hFFFF);
    step();
    pins_idle();
    step();
    rst = 1'b0;
    model_reset();
    bus_read(10'h004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
